regfile_mp: RTL

Parametrised multi-port integer register file with internal write-to-read bypass and a per-register busy scoreboard, the successor to the single-write negedge register file in the decode stage. It serves the pipelined core: decode reads operands and busy status, issue marks destination registers pending, writeback ports commit results. All storage updates happen on the rising edge, and same-cycle writeback values are forwarded to the read ports combinationally. x0 is hardwired to zero and is never busy.

---
 rtl/regfile_mp.sv | 120 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write-to-read bypass and a
// per-register busy scoreboard. x0 reads as zero and is never busy.
module regfile_mp #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 2,
  parameter int unsigned DBG_REG = 10,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wa,
  input  logic [NWR*XLEN-1:0]  wd,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_rd,
  input  logic                 flush,
  output logic [XLEN-1:0]      dbg_out
);

  if (NREGS < 2 || NREGS > 64 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("regfile_mp: NREGS must be a power of two in 2..64");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_mp: NRD must be in 1..4");
  end
  if (NWR < 1 || NWR > 2) begin : g_bad_nwr
    $error("regfile_mp: NWR must be in 1..2");
  end
  if (DBG_REG >= NREGS) begin : g_bad_dbg
    $error("regfile_mp: DBG_REG must index an existing register");
  end
  if (XLEN < 1) begin : g_bad_xlen
    $error("regfile_mp: XLEN must be nonzero");
  end

  localparam logic [AW-1:0] DbgIdx = AW'(DBG_REG);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Storage next state: later ports overwrite earlier ones, so port 1 wins a collision.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && wa[j*AW +: AW] != '0) begin
        regs_d[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  // Busy next state: flush dominates; otherwise clears first, then the issue set on top.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && wa[j*AW +: AW] != '0) begin
          busy_d[wa[j*AW +: AW]] = 1'b0;
        end
      end
      if (iss_en && iss_rd != '0) begin
        busy_d[iss_rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = ra[i*AW +: AW];

    // Bypass is suppressed in reset so the ports read the cleared state.
    always_comb begin
      data = regs_q[addr];
      busy = busy_q[addr];
      for (int j = 0; j < NWR; j++) begin
        if (rst_n && we[j] && wa[j*AW +: AW] == addr) begin
          data = wd[j*XLEN +: XLEN];
          busy = 1'b0;
        end
      end
      if (addr == '0) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rdata[i*XLEN +: XLEN] = data;
    assign rbusy[i]              = busy;
  end

  if (DBG_REG == 0) begin : g_dbg_zero
    assign dbg_out = '0;
  end else begin : g_dbg_reg
    assign dbg_out = regs_q[DbgIdx];
  end

endmodule
